// File: rtl/blinker_sequencer.sv
// blinker_sequencer: arbitrates hazard/turn/brake requests onto tail lamps with a prescaled sweep.
// Ports: ADC_CLK_10 clock, RESET_N async active-low reset, hazard_req/turn_en/turn_right/brake_req
// async request levels, led_left/led_right lamps (bit0 innermost), state_code HEX0 code, step_tick step pulse.
module blinker_sequencer #(
  parameter int TICK_DIV = 4
) (
  input  logic       ADC_CLK_10,
  input  logic       RESET_N,
  input  logic       hazard_req,
  input  logic       turn_en,
  input  logic       turn_right,
  input  logic       brake_req,
  output logic [2:0] led_left,
  output logic [2:0] led_right,
  output logic [1:0] state_code,
  output logic       step_tick
);
  localparam int CW = $clog2(TICK_DIV);
  typedef enum logic [3:0] {IDLE, HAZ_ON, HAZ_OFF, L1, L2, L3, L0, R1, R2, R3, R0} state_t;
  logic [3:0]    r_sync1, r_sync2;
  logic [CW-1:0] r_cnt;
  state_t        r_state, w_next;
  logic          w_tick, w_haz, w_turn, w_right, w_brk, w_is_l, w_is_r;
  logic [2:0]    w_phase, w_base_l, w_base_r;
  logic [1:0]    w_code;
  assign {w_haz, w_turn, w_right, w_brk} = r_sync2;
  assign w_tick = r_cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge ADC_CLK_10 or negedge RESET_N)
    if (!RESET_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cnt   <= '0;
      r_state <= IDLE;
    end else begin
      r_sync1 <= {hazard_req, turn_en, turn_right, brake_req};
      r_sync2 <= r_sync1;
      r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
      r_state <= w_next;
    end
  always_comb begin
    w_next = r_state;
    if (w_tick) begin
      if (w_haz)
        w_next = (r_state == HAZ_ON) ? HAZ_OFF : HAZ_ON;
      else if (w_turn && !w_right)
        case (r_state)
          L1:      w_next = L2;
          L2:      w_next = L3;
          L3:      w_next = L0;
          default: w_next = L1;
        endcase
      else if (w_turn)
        case (r_state)
          R1:      w_next = R2;
          R2:      w_next = R3;
          R3:      w_next = R0;
          default: w_next = R1;
        endcase
      else
        w_next = IDLE;
    end
  end
  // Sweep phase k fills lamps inner->outer: k=1 001, k=2 011, k=3 111, k=0 000.
  always_comb begin
    w_phase = 3'b000;
    w_is_l  = 1'b0;
    w_is_r  = 1'b0;
    w_code  = 2'd0;
    case (r_state)
      HAZ_ON, HAZ_OFF: w_code = 2'd1;
      L1: begin w_is_l = 1'b1; w_code = 2'd2; w_phase = 3'b001; end
      L2: begin w_is_l = 1'b1; w_code = 2'd2; w_phase = 3'b011; end
      L3: begin w_is_l = 1'b1; w_code = 2'd2; w_phase = 3'b111; end
      L0: begin w_is_l = 1'b1; w_code = 2'd2; end
      R1: begin w_is_r = 1'b1; w_code = 2'd3; w_phase = 3'b001; end
      R2: begin w_is_r = 1'b1; w_code = 2'd3; w_phase = 3'b011; end
      R3: begin w_is_r = 1'b1; w_code = 2'd3; w_phase = 3'b111; end
      R0: begin w_is_r = 1'b1; w_code = 2'd3; end
      default: w_code = 2'd0;
    endcase
  end
  assign w_base_l = (r_state == HAZ_ON) ? 3'b111 : (w_is_l ? w_phase : 3'b000);
  assign w_base_r = (r_state == HAZ_ON) ? 3'b111 : (w_is_r ? w_phase : 3'b000);
  // Brake lights every side that is not actively sweeping; HAZ_ON is already full on.
  assign led_left   = w_base_l | {3{w_brk & ~w_is_l}};
  assign led_right  = w_base_r | {3{w_brk & ~w_is_r}};
  assign state_code = w_code;
  assign step_tick  = w_tick;
endmodule

// File: tb/tb_blinker_sequencer.sv
// tb_blinker_sequencer: directed table-driven bench for blinker_sequencer.
module tb_blinker_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hz = 1'b0, te = 1'b0, tr = 1'b0, bk = 1'b0;
  logic [2:0] led_left, led_right;
  logic [1:0] state_code;
  logic step_tick;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic [3:0] in;
    logic [2:0] el;
    logic [2:0] er;
    logic [1:0] ec;
  } vec_t;
  vec_t vecs [0:31];
  int nv = 0;
  blinker_sequencer #(.TICK_DIV(4)) dut (
    .ADC_CLK_10(clk), .RESET_N(rst_n), .hazard_req(hz), .turn_en(te), .turn_right(tr),
    .brake_req(bk), .led_left(led_left), .led_right(led_right), .state_code(state_code),
    .step_tick(step_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%b expected=%b", name, idx, got, exp);
    end
  endtask
  task automatic add(input logic [3:0] in, input logic [2:0] el, input logic [2:0] er, input logic [1:0] ec);
    vecs[nv] = '{in: in, el: el, er: er, ec: ec};
    nv++;
  endtask
  task automatic do_step(input logic [3:0] in, input int idx);
    int n = 0;
    bit done = 1'b0;
    {hz, te, tr, bk} = in;
    while (!done && n < 8) begin
      done = step_tick;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout[%0d] got=no_tick expected=tick", idx);
    end
  endtask
  initial begin
    // Reset behaviour and free-running tick cadence.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 0, {led_left, led_right, state_code}, 8'd0);
    chk("reset_tick", 0, {7'd0, step_tick}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      chk("tick_cadence", k, {7'd0, step_tick}, {7'd0, k % 4 == 3});
      chk("idle_code", k, {6'd0, state_code}, 8'd0);
    end
    // Table: {hazard,turn_en,turn_right,brake}, expected left/right/code after the next tick.
    add(4'b0000, 3'b000, 3'b000, 2'd0);
    add(4'b1000, 3'b111, 3'b111, 2'd1);
    add(4'b1000, 3'b000, 3'b000, 2'd1);
    add(4'b1000, 3'b111, 3'b111, 2'd1);
    add(4'b1000, 3'b000, 3'b000, 2'd1);
    add(4'b0100, 3'b001, 3'b000, 2'd2);
    add(4'b0100, 3'b011, 3'b000, 2'd2);
    add(4'b0100, 3'b111, 3'b000, 2'd2);
    add(4'b0100, 3'b000, 3'b000, 2'd2);
    add(4'b0100, 3'b001, 3'b000, 2'd2);
    add(4'b0100, 3'b011, 3'b000, 2'd2);
    add(4'b0110, 3'b000, 3'b001, 2'd3);
    add(4'b0110, 3'b000, 3'b011, 2'd3);
    add(4'b0110, 3'b000, 3'b111, 2'd3);
    add(4'b0110, 3'b000, 3'b000, 2'd3);
    add(4'b0110, 3'b000, 3'b001, 2'd3);
    add(4'b0111, 3'b111, 3'b011, 2'd3);
    add(4'b0111, 3'b111, 3'b111, 2'd3);
    add(4'b0111, 3'b111, 3'b000, 2'd3);
    add(4'b0001, 3'b111, 3'b111, 2'd0);
    add(4'b0000, 3'b000, 3'b000, 2'd0);
    add(4'b1001, 3'b111, 3'b111, 2'd1);
    add(4'b1001, 3'b111, 3'b111, 2'd1);
    add(4'b0101, 3'b001, 3'b111, 2'd2);
    add(4'b0100, 3'b011, 3'b000, 2'd2);
    add(4'b1100, 3'b111, 3'b111, 2'd1);
    add(4'b0100, 3'b001, 3'b000, 2'd2);
    for (int i = 0; i < nv; i++) begin
      do_step(vecs[i].in, i);
      chk("vec_left", i, {5'd0, led_left}, {5'd0, vecs[i].el});
      chk("vec_right", i, {5'd0, led_right}, {5'd0, vecs[i].er});
      chk("vec_code", i, {6'd0, state_code}, {6'd0, vecs[i].ec});
    end
    // Brake reaches the idle side two cycles after the input, without a tick.
    do_step(4'b0110, 100);
    chk("brk_r1", 0, {led_left, led_right, state_code}, {3'b000, 3'b001, 2'd3});
    bk = 1'b1;
    @(posedge clk);
    #1;
    chk("brk_lat1", 0, {led_left, led_right, state_code}, {3'b000, 3'b001, 2'd3});
    @(posedge clk);
    #1;
    chk("brk_lat2", 0, {led_left, led_right, state_code}, {3'b111, 3'b001, 2'd3});
    chk("brk_notick", 0, {7'd0, step_tick}, 8'd0);
    do_step(4'b0111, 101);
    chk("brk_r2", 0, {led_left, led_right, state_code}, {3'b111, 3'b011, 2'd3});
    do_step(4'b0110, 102);
    chk("r3", 0, {led_left, led_right, state_code}, {3'b000, 3'b111, 2'd3});
    // Hazard preempts R3, then asynchronous reset mid-sequence.
    do_step(4'b1110, 103);
    chk("haz_preempt", 0, {led_left, led_right, state_code}, {3'b111, 3'b111, 2'd1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 0, {led_left, led_right, state_code}, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk("hold_rst", k, {led_left, led_right, state_code, 1'b0}, {7'd0, step_tick});
      chk("hold_rst_tick", k, {7'd0, step_tick}, 8'd0);
    end
    {hz, te, tr, bk} = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_tick", k, {7'd0, step_tick}, {7'd0, k == 3});
      chk("post_rst_outs", k, {led_left, led_right, state_code}, 8'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
